// File: rtl/led_ctrl.sv
// Multichannel LED driver: each channel is OFF, ON, BLINK or PWM, all sharing one
// prescaled time base and one PWM phase counter so PWM channels stay aligned.
module led_ctrl #(
    parameter int NCH   = 8,
    parameter int PRESC = 100000,
    parameter int CNT_W = 16,
    parameter int PWM_W = 8
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [2*NCH-1:0]       mode_i,
    input  logic [CNT_W*NCH-1:0]   half_per_i,
    input  logic [PWM_W*NCH-1:0]   duty_i,
    output logic [NCH-1:0]         led_o,
    output logic                   tick_o
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [PW-1:0]    presc_cnt_q, presc_cnt_d;
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [2*NCH-1:0] prev_mode_q;
    logic [NCH-1:0]   led_d;
    logic             tick;

    assign tick = (presc_cnt_q == PW'(PRESC - 1));

    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + PW'(1);
        pwm_cnt_d   = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [1:0]       mode_k, prev_k;
        logic [CNT_W-1:0] hp_k, hp_m1;
        logic [PWM_W-1:0] duty_k;
        logic [CNT_W-1:0] bl_cnt_q, bl_cnt_d;
        logic             phase_q, phase_d;
        logic             entry;
        logic             led_k;

        assign mode_k = mode_i[2*k +: 2];
        assign prev_k = prev_mode_q[2*k +: 2];
        assign hp_k   = half_per_i[CNT_W*k +: CNT_W];
        assign duty_k = duty_i[PWM_W*k +: PWM_W];
        // A zero half-period behaves as one tick.
        assign hp_m1  = (hp_k == '0) ? '0 : hp_k - CNT_W'(1);
        assign entry  = (mode_k != prev_k) && (mode_k == MODE_BLINK);

        always_comb begin
            bl_cnt_d = bl_cnt_q;
            phase_d  = phase_q;
            if (entry) begin
                bl_cnt_d = '0;
                phase_d  = 1'b1;
            end else if ((mode_k == MODE_BLINK) && tick) begin
                if (bl_cnt_q >= hp_m1) begin
                    bl_cnt_d = '0;
                    phase_d  = ~phase_q;
                end else begin
                    bl_cnt_d = bl_cnt_q + CNT_W'(1);
                end
            end
        end

        // BLINK shows the updated phase so a fresh entry lights on the next edge.
        always_comb begin
            led_k = 1'b0;
            case (mode_k)
                MODE_OFF:   led_k = 1'b0;
                MODE_ON:    led_k = 1'b1;
                MODE_BLINK: led_k = phase_d;
                MODE_PWM:   led_k = (pwm_cnt_q < duty_k);
                default:    led_k = 1'b0;
            endcase
        end

        assign led_d[k] = led_k;

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                bl_cnt_q <= '0;
                phase_q  <= 1'b0;
            end else begin
                bl_cnt_q <= bl_cnt_d;
                phase_q  <= phase_d;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            prev_mode_q <= '0;
            led_o       <= '0;
            tick_o      <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            prev_mode_q <= mode_i;
            led_o       <= led_d;
            tick_o      <= tick;
        end
    end

endmodule
